uart_cmd_arbiter: RTL and testbench
===================================

UART_CMD_ARBITER -- requirements
Module: uart_cmd_arbiter

Interface
REQ-001 SHALL have parameters: NUM_REQ, default 4, number of requesters; CMD_WIDTH, default 16, command width; READ_WIDTH, default 8, read data width; TIMEOUT, default 65535, max cycles per transaction.
REQ-002 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port m_req  input  NUM_REQ  per-requester request, held until m_ack.
REQ-005 SHALL have port m_cmd  input  NUM_REQ*CMD_WIDTH  per-requester command; slice i = [i*CMD_WIDTH +: CMD_WIDTH].
REQ-006 SHALL have port m_ack  output  NUM_REQ  one-cycle pulse when that requester's command is transferred to the UART.
REQ-007 SHALL have port m_rsp_vld  output  NUM_REQ  one-cycle pulse when read data is returned to that requester.
REQ-008 SHALL have port m_rsp_data  output  READ_WIDTH  read data, shared; valid only with m_rsp_vld.
REQ-009 SHALL have port m_err  output  NUM_REQ  one-cycle timeout pulse for the owning requester.
REQ-010 SHALL have port u_cmd_in  output  CMD_WIDTH  command to UART.
REQ-011 SHALL have port u_cmd_vld  output  1  command valid to UART.
REQ-012 SHALL have port u_cmd_rdy  input  1  UART idle / ready for a command.
REQ-013 SHALL have port u_read_rdy  input  1  UART read-data strobe.
REQ-014 SHALL have port u_read_data  input  READ_WIDTH  UART read data.

Function
REQ-015 SHALL decode commands as: bit 15 = 1 read, 0 write; bits 14:8 address; bits 7:0 write data (ignored for reads).
REQ-016 SHALL implement states IDLE, ISSUE, GUARD, BUSY, WAIT_RSP.
REQ-017 In IDLE with any m_req set, SHALL grant round-robin starting at pointer rr_ptr, latch m_cmd slice and read flag, and enter ISSUE next cycle; latency req->u_cmd_vld = 1 cycle.
REQ-018 After a grant to i, SHALL set rr_ptr = (i+1) mod NUM_REQ; requests arriving outside IDLE wait.
REQ-019 In ISSUE, SHALL hold u_cmd_vld=1 and u_cmd_in=latched command until u_cmd_vld&&u_cmd_rdy, then pulse m_ack[grant] in the following cycle and enter GUARD.
REQ-020 GUARD SHALL last exactly one cycle, ignoring u_cmd_rdy, then enter BUSY.
REQ-021 BUSY SHALL wait for u_cmd_rdy=1; write -> IDLE; read with response already captured -> IDLE; read without response -> WAIT_RSP.
REQ-022 In GUARD/BUSY/WAIT_RSP, for a pending read, the first u_read_rdy SHALL capture u_read_data and pulse m_rsp_vld[grant] with m_rsp_data in the next cycle; WAIT_RSP -> IDLE on that capture.
REQ-023 u_read_rdy while no read is pending, or a second strobe for the same read, SHALL be ignored.
REQ-024 A 16-bit cycle counter SHALL clear on IDLE->ISSUE and increment in all non-IDLE states; on reaching TIMEOUT-1, pulse m_err[grant], drop u_cmd_vld, no m_ack/m_rsp_vld, return to IDLE.
REQ-025 Requester dropping m_req after grant SHALL NOT cancel the latched command.
REQ-026 At most one bit of m_ack, m_rsp_vld, m_err SHALL be set per cycle, and never two of these for the same transaction in the same cycle.

Reset
REQ-027 On rst: state=IDLE, rr_ptr=0, counter=0, u_cmd_vld=0, u_cmd_in=0, m_ack=0, m_rsp_vld=0, m_rsp_data=0, m_err=0.
REQ-028 Reset mid-transaction SHALL abandon it with no ack/response/error pulse; next cycle after deassert arbitration restarts at requester 0.

Structure
REQ-029 Shared package SHALL hold command field positions (RD_BIT=15, ADDR 14:8, DATA 7:0), state encoding and default widths.
REQ-030 Round-robin grant logic SHALL be a sub-module rr_arbiter (inputs req, ptr; output one-hot grant).

Verification
REQ-031 Write: m_req[0]=1, m_cmd0=16'h4C3F, u_cmd_rdy=1 -> u_cmd_vld 1 cycle later with u_cmd_in=16'h4C3F, m_ack=4'b0001, IDLE after u_cmd_rdy returns.
REQ-032 Read: m_req[2], cmd 16'h8500; model asserts u_read_rdy with 8'hA5 -> m_rsp_vld=4'b0100, m_rsp_data=8'hA5 one cycle later.
REQ-033 Fairness: m_req=4'b1111 held with re-requests -> ack order 0,1,2,3,0.
REQ-034 Timeout: TIMEOUT=32, u_cmd_rdy stuck 0 -> m_err[1] pulse 32 cycles after ISSUE entry, u_cmd_vld=0, no m_ack.
REQ-035 Reset in WAIT_RSP, then u_read_rdy -> no m_rsp_vld; fresh request from requester 3 granted normally.

Source files
------------

// File: rtl/uart_cmd_arbiter_pkg.sv
// uart_cmd_arbiter_pkg: command field layout, FSM encoding and default sizes.
// Rev 1.0
`default_nettype none

package uart_cmd_arbiter_pkg;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_CMD_WIDTH  = 16;
  localparam int DEF_READ_WIDTH = 8;
  localparam int DEF_TIMEOUT    = 65535;
  localparam int CNT_WIDTH      = 16;

  localparam int RD_BIT   = 15;
  localparam int ADDR_MSB = 14;
  localparam int ADDR_LSB = 8;
  localparam int DATA_MSB = 7;
  localparam int DATA_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ISSUE    = 3'd1,
    ST_GUARD    = 3'd2,
    ST_BUSY     = 3'd3,
    ST_WAIT_RSP = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/uart_cmd_arbiter_rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant, searching upward from ptr with wrap.
// Rev 1.0
`default_nettype none

module rr_arbiter
  import uart_cmd_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant
);

  logic [NUM_REQ-1:0] rot_req;
  logic [NUM_REQ-1:0] rot_gnt;

  // Rotate so ptr lands at bit 0, take the lowest set bit, rotate back.
  always_comb begin
    rot_req = NUM_REQ'({req, req} >> ptr);
    rot_gnt = rot_req & (~rot_req + NUM_REQ'(1));
    grant   = NUM_REQ'(({rot_gnt, rot_gnt} << ptr) >> NUM_REQ);
  end

endmodule

`default_nettype wire

// File: rtl/uart_cmd_arbiter.sv
// uart_cmd_arbiter: round-robin sharing of one UART command port between requesters.
// Rev 1.0
`default_nettype none

module uart_cmd_arbiter
  import uart_cmd_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int CMD_WIDTH  = DEF_CMD_WIDTH,
  parameter int READ_WIDTH = DEF_READ_WIDTH,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             m_req,
  input  logic [NUM_REQ*CMD_WIDTH-1:0]   m_cmd,
  output logic [NUM_REQ-1:0]             m_ack,
  output logic [NUM_REQ-1:0]             m_rsp_vld,
  output logic [READ_WIDTH-1:0]          m_rsp_data,
  output logic [NUM_REQ-1:0]             m_err,
  output logic [CMD_WIDTH-1:0]           u_cmd_in,
  output logic                           u_cmd_vld,
  input  logic                           u_cmd_rdy,
  input  logic                           u_read_rdy,
  input  logic [READ_WIDTH-1:0]          u_read_data
);

  localparam int                   PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CNT_WIDTH-1:0] TO_LAST = CNT_WIDTH'(TIMEOUT - 1);

  state_t                 state;
  logic [PTR_W-1:0]       rr_ptr;
  logic [CNT_WIDTH-1:0]   cnt;
  logic [NUM_REQ-1:0]     owner;
  logic                   is_read;
  logic                   rsp_done;

  logic [NUM_REQ-1:0]     grant;
  logic [PTR_W-1:0]       win_idx;
  logic [PTR_W-1:0]       next_ptr;
  logic [CMD_WIDTH-1:0]   sel_cmd;
  logic                   capture;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_arbiter (
    .req   (m_req),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  always_comb begin
    win_idx = '0;
    sel_cmd = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        win_idx = PTR_W'(i);
        sel_cmd = m_cmd[i*CMD_WIDTH +: CMD_WIDTH];
      end
    end
    next_ptr = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
  end

  // Only the first strobe of an outstanding read, after the command left, is taken.
  assign capture = is_read && !rsp_done && u_read_rdy &&
                   ((state == ST_GUARD) || (state == ST_BUSY) || (state == ST_WAIT_RSP));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      rr_ptr     <= '0;
      cnt        <= '0;
      owner      <= '0;
      is_read    <= 1'b0;
      rsp_done   <= 1'b0;
      u_cmd_vld  <= 1'b0;
      u_cmd_in   <= '0;
      m_ack      <= '0;
      m_rsp_vld  <= '0;
      m_rsp_data <= '0;
      m_err      <= '0;
    end else begin
      m_ack     <= '0;
      m_rsp_vld <= '0;
      m_err     <= '0;
      // Timeout wins over any handshake or capture seen in the same cycle.
      if ((state != ST_IDLE) && (cnt == TO_LAST)) begin
        m_err     <= owner;
        u_cmd_vld <= 1'b0;
        state     <= ST_IDLE;
      end else begin
        if (state != ST_IDLE) cnt <= cnt + 1'b1;
        if (capture) begin
          m_rsp_vld  <= owner;
          m_rsp_data <= u_read_data;
          rsp_done   <= 1'b1;
        end
        case (state)
          ST_IDLE: begin
            if (|m_req) begin
              owner     <= grant;
              rr_ptr    <= next_ptr;
              u_cmd_in  <= sel_cmd;
              is_read   <= sel_cmd[RD_BIT];
              rsp_done  <= 1'b0;
              cnt       <= '0;
              u_cmd_vld <= 1'b1;
              state     <= ST_ISSUE;
            end
          end
          ST_ISSUE: begin
            if (u_cmd_rdy) begin
              u_cmd_vld <= 1'b0;
              m_ack     <= owner;
              state     <= ST_GUARD;
            end
          end
          ST_GUARD: state <= ST_BUSY;
          ST_BUSY: begin
            if (u_cmd_rdy)
              state <= (!is_read || rsp_done || capture) ? ST_IDLE : ST_WAIT_RSP;
          end
          ST_WAIT_RSP: begin
            if (capture) state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_cmd_arbiter.sv
// tb_uart_cmd_arbiter: scoreboard bench for uart_cmd_arbiter.
// Rev 1.0
`default_nettype none

module tb_uart_cmd_arbiter;

  localparam int NR = 4;
  localparam int CW = 16;
  localparam int RW = 8;
  localparam int TO = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     m_req;
  logic [NR*CW-1:0]  m_cmd;
  logic [NR-1:0]     m_ack;
  logic [NR-1:0]     m_rsp_vld;
  logic [RW-1:0]     m_rsp_data;
  logic [NR-1:0]     m_err;
  logic [CW-1:0]     u_cmd_in;
  logic              u_cmd_vld;
  logic              u_cmd_rdy;
  logic              u_read_rdy;
  logic [RW-1:0]     u_read_data;

  uart_cmd_arbiter #(
    .NUM_REQ    (NR),
    .CMD_WIDTH  (CW),
    .READ_WIDTH (RW),
    .TIMEOUT    (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .m_req       (m_req),
    .m_cmd       (m_cmd),
    .m_ack       (m_ack),
    .m_rsp_vld   (m_rsp_vld),
    .m_rsp_data  (m_rsp_data),
    .m_err       (m_err),
    .u_cmd_in    (u_cmd_in),
    .u_cmd_vld   (u_cmd_vld),
    .u_cmd_rdy   (u_cmd_rdy),
    .u_read_rdy  (u_read_rdy),
    .u_read_data (u_read_data)
  );

  always #5 clk = ~clk;

  // kind: 0 = ack, 1 = read response, 2 = timeout error
  typedef struct {
    int            kind;
    logic [NR-1:0] who;
    logic [RW-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input int kind, input logic [NR-1:0] who, input logic [RW-1:0] data);
    exp_t e;
    e.kind = kind;
    e.who  = who;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [CW-1:0] cmd);
    m_cmd[i*CW +: CW] = cmd;
    m_req[i]          = 1'b1;
  endtask

  // Returns at the negedge where any ack/rsp/err pulse is visible.
  task automatic wait_pulse(input string tag, input int max_cyc, output int n);
    bit seen;
    seen = 1'b0;
    n    = 0;
    while (!seen && n < max_cyc) begin
      @(negedge clk);
      n++;
      if ((m_ack | m_rsp_vld | m_err) != '0) seen = 1'b1;
    end
    check({"wait_", tag}, 32'(seen), 32'd1);
  endtask

  logic [3*NR-1:0] mon_pulses;
  exp_t            mon_e;
  int              mon_kind;
  logic [NR-1:0]   mon_who;

  always @(negedge clk) begin
    mon_pulses = {m_err, m_rsp_vld, m_ack};
    if (mon_pulses != '0) begin
      check("one_pulse", 32'($countones(mon_pulses)), 32'd1);
      if (sb.size() == 0) begin
        check("unexpected_pulse", 32'(mon_pulses), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        if (m_ack != '0) begin
          mon_kind = 0;
          mon_who  = m_ack;
        end else if (m_rsp_vld != '0) begin
          mon_kind = 1;
          mon_who  = m_rsp_vld;
        end else begin
          mon_kind = 2;
          mon_who  = m_err;
        end
        check("sb_kind", 32'(mon_kind), 32'(mon_e.kind));
        check("sb_who", 32'(mon_who), 32'(mon_e.who));
        if (mon_e.kind == 1) check("sb_rsp_data", 32'(m_rsp_data), 32'(mon_e.data));
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst         = 1'b1;
    m_req       = '0;
    m_cmd       = '0;
    u_cmd_rdy   = 1'b0;
    u_read_rdy  = 1'b0;
    u_read_data = '0;
    repeat (3) tick();
    check("rst_u_cmd_vld", 32'(u_cmd_vld), 32'd0);
    check("rst_u_cmd_in", 32'(u_cmd_in), 32'd0);
    check("rst_m_ack", 32'(m_ack), 32'd0);
    check("rst_m_rsp_vld", 32'(m_rsp_vld), 32'd0);
    check("rst_m_rsp_data", 32'(m_rsp_data), 32'd0);
    check("rst_m_err", 32'(m_err), 32'd0);
    rst       = 1'b0;
    u_cmd_rdy = 1'b1;

    // Read strobe with nothing outstanding must be ignored.
    u_read_rdy  = 1'b1;
    u_read_data = 8'hFF;
    tick();
    u_read_rdy = 1'b0;
    tick();
    check("idle_strobe", 32'(m_rsp_vld), 32'd0);

    // Write from requester 0.
    push(0, 4'b0001, '0);
    set_req(0, 16'h4C3F);
    tick();
    check("wr_vld", 32'(u_cmd_vld), 32'd1);
    check("wr_cmd", 32'(u_cmd_in), 32'h4C3F);
    wait_pulse("wr_ack", 10, cyc);
    tick();
    m_req[0] = 1'b0;
    check("wr_vld_drop", 32'(u_cmd_vld), 32'd0);
    repeat (2) tick();

    // Read from requester 2, data returned while in WAIT_RSP.
    push(0, 4'b0100, '0);
    push(1, 4'b0100, 8'hA5);
    set_req(2, 16'h8500);
    tick();
    check("rd2_vld", 32'(u_cmd_vld), 32'd1);
    check("rd2_cmd", 32'(u_cmd_in), 32'h8500);
    wait_pulse("rd2_ack", 10, cyc);
    tick();
    m_req[2] = 1'b0;
    tick();
    u_read_rdy  = 1'b1;
    u_read_data = 8'hA5;
    tick();
    check("rd2_rsp_vld", 32'(m_rsp_vld), 32'b0100);
    check("rd2_rsp_data", 32'(m_rsp_data), 32'hA5);
    u_read_data = 8'h5A;
    tick();
    u_read_rdy = 1'b0;
    check("rd2_no_extra", 32'(m_rsp_vld), 32'd0);

    // Read from requester 1, data arrives in GUARD; second strobe in BUSY ignored.
    push(0, 4'b0010, '0);
    push(1, 4'b0010, 8'h3C);
    set_req(1, 16'h9A00);
    tick();
    check("rd1_vld", 32'(u_cmd_vld), 32'd1);
    wait_pulse("rd1_ack", 10, cyc);
    m_req[1]    = 1'b0;
    u_read_rdy  = 1'b1;
    u_read_data = 8'h3C;
    tick();
    check("rd1_rsp_vld", 32'(m_rsp_vld), 32'b0010);
    check("rd1_rsp_data", 32'(m_rsp_data), 32'h3C);
    u_read_data = 8'h11;
    tick();
    u_read_rdy = 1'b0;
    check("rd1_no_dup", 32'(m_rsp_vld), 32'd0);
    // BUSY must have gone straight back to IDLE: next request issues one cycle later.
    push(0, 4'b1000, '0);
    set_req(3, 16'h3344);
    tick();
    check("rd1_idle_vld", 32'(u_cmd_vld), 32'd1);
    check("rd1_idle_cmd", 32'(u_cmd_in), 32'h3344);
    wait_pulse("r3_ack", 10, cyc);
    tick();
    m_req[3] = 1'b0;
    repeat (3) tick();

    // Fairness from a freshly reset pointer, all requesters held.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < NR; i++) m_cmd[i*CW +: CW] = 16'(16'h0100 * (i + 1) + i);
    push(0, 4'b0001, '0);
    push(0, 4'b0010, '0);
    push(0, 4'b0100, '0);
    push(0, 4'b1000, '0);
    push(0, 4'b0001, '0);
    m_req = 4'b1111;
    for (int k = 0; k < 5; k++) wait_pulse("fair_ack", 10, cyc);
    tick();
    m_req = '0;
    repeat (3) tick();

    // Timeout on requester 1 with the UART never ready.
    u_cmd_rdy = 1'b0;
    push(2, 4'b0010, '0);
    set_req(1, 16'h2211);
    tick();
    check("to_vld", 32'(u_cmd_vld), 32'd1);
    wait_pulse("to_err", TO + 8, cyc);
    m_req[1] = 1'b0;
    // ISSUE began at the edge just before the first sampled negedge; err is 32 edges on.
    check("to_cycles", 32'(cyc), 32'(TO + 1));
    check("to_vld_drop", 32'(u_cmd_vld), 32'd0);
    u_cmd_rdy = 1'b1;
    repeat (2) tick();

    // Reset while waiting for read data, then a late strobe.
    push(0, 4'b0100, '0);
    set_req(2, 16'h8377);
    wait_pulse("rr_ack", 10, cyc);
    tick();
    m_req[2] = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rr_vld_after_rst", 32'(u_cmd_vld), 32'd0);
    u_read_rdy  = 1'b1;
    u_read_data = 8'h77;
    tick();
    u_read_rdy = 1'b0;
    check("rr_no_rsp", 32'(m_rsp_vld), 32'd0);
    tick();
    check("rr_no_rsp_late", 32'(m_rsp_vld), 32'd0);
    push(0, 4'b1000, '0);
    set_req(3, 16'h0F0F);
    tick();
    check("rr_r3_vld", 32'(u_cmd_vld), 32'd1);
    check("rr_r3_cmd", 32'(u_cmd_in), 32'h0F0F);
    wait_pulse("rr_r3_ack", 10, cyc);
    tick();
    m_req[3] = 1'b0;
    repeat (4) tick();

    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
